seven_seg_capture: RTL

Decoder at the far end of the seven-segment display interface. It samples the multiplexed column strobe and segment bus, waits for each column to settle, and decodes each segment pattern back to a 4-bit digit. It assembles a full 8-digit frame and commits it in one cycle with a status mask. It serves as the on-chip loopback and self-check monitor for the candy vending display path, and is also reused as the bench scoreboard front-end.

---
 rtl/seven_seg_capture_if.sv | 24 ++
 rtl/seven_seg_capture.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seven_seg_capture_if.sv
// Signal bundle between a seven-segment display driver and its capture monitor.
// The master side drives the strobe and segment bus; the slave decodes and reports.
interface seven_seg_capture_if;
  logic [7:0]  display_column;
  logic [7:0]  out;
  logic        clr_err;
  logic [31:0] digits;
  logic [7:0]  blank_mask;
  logic [7:0]  err_mask;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic        stale;
  logic        col_err;

  modport master (
    output display_column, out, clr_err,
    input  digits, blank_mask, err_mask, dp_mask, frame_valid, stale, col_err
  );

  modport slave (
    input  display_column, out, clr_err,
    output digits, blank_mask, err_mask, dp_mask, frame_valid, stale, col_err
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment loopback monitor: samples the multiplexed strobe/segment bus, waits for
// each column to settle, decodes it and commits a full 8-digit frame with status masks.
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT        = 100000,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seven_seg_capture_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 3);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] seg);
    dec_t d;
    d = '{err: 1'b0, blank: 1'b0, digit: 4'h0};
    case (seg)
      7'h3F: d.digit = 4'h0;
      7'h06: d.digit = 4'h1;
      7'h5B: d.digit = 4'h2;
      7'h4F: d.digit = 4'h3;
      7'h66: d.digit = 4'h4;
      7'h6D: d.digit = 4'h5;
      7'h7D: d.digit = 4'h6;
      7'h07: d.digit = 4'h7;
      7'h7F: d.digit = 4'h8;
      7'h6F: d.digit = 4'h9;
      7'h77: d.digit = 4'hA;
      7'h7C: d.digit = 4'hB;
      7'h39: d.digit = 4'hC;
      7'h5E: d.digit = 4'hD;
      7'h79: d.digit = 4'hE;
      7'h71: d.digit = 4'hF;
      7'h00: d.blank = 1'b1;
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

  logic [7:0]    col_q, col_p, seg_q, seg_p;
  logic [SW-1:0] stab_cnt;
  logic          dwell;
  logic [31:0]   digit_buf;
  logic [7:0]    blank_buf, err_buf, dp_buf, cap_mask;
  logic [TW-1:0] to_cnt;

  logic          same, one_hot, multi_hot, capture, commit;
  logic [SW-1:0] run_len;
  logic [TW-1:0] to_next;
  dec_t          dec;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    same      = (col_q == col_p) && (seg_q == seg_p);
    // Samples of the current value so far, including the one in col_q/seg_q.
    run_len   = same ? stab_cnt + SW'(2) : SW'(1);
    one_hot   = (col_q != 8'h00) && ((col_q & (col_q - 8'd1)) == 8'h00);
    multi_hot = (col_q != 8'h00) && !one_hot;
    // A change in the bus starts a fresh dwell, so the old dwell flag no longer blocks.
    capture   = one_hot && (run_len >= STABLE_MAX) && !(same && dwell);
    commit    = (cap_mask == 8'hFF);
    to_next   = commit ? '0 : ((to_cnt == TIMEOUT_MAX) ? to_cnt : to_cnt + TW'(1));
    dec       = decode(seg_q[6:0]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q           <= '0;
      col_p           <= '0;
      seg_q           <= '0;
      seg_p           <= '0;
      stab_cnt        <= '0;
      dwell           <= 1'b0;
      // NOTE: the capture buffer is reset too, so a frame interrupted by reset cannot leak out.
      digit_buf       <= '0;
      blank_buf       <= '0;
      err_buf         <= '0;
      dp_buf          <= '0;
      cap_mask        <= '0;
      to_cnt          <= '0;
      bus.digits      <= '0;
      bus.blank_mask  <= '0;
      bus.err_mask    <= '0;
      bus.dp_mask     <= '0;
      bus.frame_valid <= 1'b0;
      bus.stale       <= 1'b0;
      bus.col_err     <= 1'b0;
    end else begin
      col_q    <= COL_ACTIVE_LOW ? ~bus.display_column : bus.display_column;
      seg_q    <= SEG_ACTIVE_LOW ? ~bus.out : bus.out;
      col_p    <= col_q;
      seg_p    <= seg_q;
      stab_cnt <= !same ? '0 : ((stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + SW'(1));
      dwell    <= capture || (same && dwell);

      for (int k = 0; k < 8; k++) begin
        if (capture && col_q[k]) begin
          digit_buf[4*k +: 4] <= dec.digit;
          blank_buf[k]        <= dec.blank;
          err_buf[k]          <= dec.err;
          dp_buf[k]           <= seg_q[7];
        end
      end

      // A capture on the commit cycle belongs to the next frame.
      cap_mask <= (commit ? 8'h00 : cap_mask) | (capture ? col_q : 8'h00);

      if (commit) begin
        bus.digits     <= digit_buf;
        bus.blank_mask <= blank_buf;
        bus.err_mask   <= err_buf;
        bus.dp_mask    <= dp_buf;
      end
      bus.frame_valid <= commit;

      to_cnt    <= to_next;
      bus.stale <= (to_next >= TIMEOUT_MAX);

      bus.col_err <= multi_hot || (bus.col_err && !bus.clr_err);
    end
  end

endmodule
